// File: rtl/mont_pkg.sv
// Constants shared by the Montgomery core, the mux datapath and its select sequencer.
package mont_pkg;

    localparam int OPERAND_W = 256;

    // Bit-counter width able to index bits 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sel_shift_reg.sv
// Active operand slot: parallel load, LSB-first shift-right with zero fill,
// bit counter and first/last flags.
module sel_shift_reg
    import mont_pkg::*;
#(
    parameter int N = OPERAND_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [N-1:0] load_data_i,
    input  logic         step_i,
    output logic         valid_o,
    output logic         bit_o,
    output logic         first_o,
    output logic         last_o
);

    localparam int CNT_W = cnt_w(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    logic [N-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_LAST);

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            sr_d    = load_data_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (step_i && valid_q) begin
            // The final shift empties the register so an idle slot always reads zero.
            sr_d = sr_q >> 1;
            if (at_last) begin
                valid_d = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign bit_o   = valid_q & sr_q[0];
    assign first_o = valid_q && (cnt_q == '0);
    assign last_o  = valid_q && at_last;

endmodule

// File: rtl/mux_sel_sequencer.sv
// Serialises N-bit operands LSB first into a mux select stream, with a pending
// buffer so the next operand can load while the current one streams.
//
// state    | active_valid,pending_full | meaning
// IDLE     | 0,0                       | nothing held, ready for a load
// RUN      | 1,0                       | streaming, pending buffer free
// RUN_PEND | 1,1                       | streaming, next operand waiting
// PEND     | 0,1                       | operand waiting, moves to shifter next edge
module mux_sel_sequencer
    import mont_pkg::*;
#(
    parameter int N = OPERAND_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] load_data,
    input  logic         step,
    output logic         sel_bit,
    output logic         sel_valid,
    output logic         first,
    output logic         last,
    output logic         busy,
    output logic         done
);

    logic         pending_full_q, pending_full_d;
    logic [N-1:0] pend_buf_q, pend_buf_d;
    logic         done_q, done_d;

    logic         act_valid;
    logic         act_bit;
    logic         act_first;
    logic         act_last;
    logic         load_fire;
    logic         step_fire;
    logic         transfer;

    // load_ready already folds in rst, so loads offered during reset are dropped.
    assign load_fire = load_valid && load_ready;
    assign step_fire = step && act_valid;
    assign transfer  = pending_full_q && (!act_valid || (step_fire && act_last));

    sel_shift_reg #(
        .N (N)
    ) u_active (
        .clk         (clk),
        .rst         (rst),
        .load_i      (transfer),
        .load_data_i (pend_buf_q),
        .step_i      (step),
        .valid_o     (act_valid),
        .bit_o       (act_bit),
        .first_o     (act_first),
        .last_o      (act_last)
    );

    always_comb begin
        pending_full_d = pending_full_q;
        pend_buf_d     = pend_buf_q;
        done_d         = step_fire && act_last;
        if (transfer) begin
            pending_full_d = 1'b0;
        end
        if (load_fire) begin
            pending_full_d = 1'b1;
            pend_buf_d     = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_full_q <= 1'b0;
            pend_buf_q     <= '0;
            done_q         <= 1'b0;
        end else begin
            pending_full_q <= pending_full_d;
            pend_buf_q     <= pend_buf_d;
            done_q         <= done_d;
        end
    end

    // Every output is forced low for the whole cycle in which rst is high.
    assign load_ready = !pending_full_q && !rst;
    assign sel_valid  = act_valid && !rst;
    assign sel_bit    = act_bit && !rst;
    assign first      = act_first && !rst;
    assign last       = act_last && !rst;
    assign busy       = (act_valid || pending_full_q) && !rst;
    assign done       = done_q && !rst;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer at N=8: directed scenarios plus random traffic,
// all checked against an operand-level reference model.
module tb_mux_sel_sequencer;

    localparam int N = 8;
    localparam int O_RDY = 6, O_VAL = 5, O_BIT = 4, O_FIRST = 3, O_LAST = 2, O_BUSY = 1, O_DONE = 0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic [N-1:0] load_data = '0;
    logic         step = 1'b0;
    logic         load_ready, sel_bit, sel_valid, first, last, busy, done;

    mux_sel_sequencer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .step       (step),
        .sel_bit    (sel_bit),
        .sel_valid  (sel_valid),
        .first      (first),
        .last       (last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the operand being streamed, which bit of it is current,
    // and the operand waiting behind it.
    bit           m_act = 1'b0;
    logic [N-1:0] m_val = '0;
    int           m_idx = 0;
    bit           m_pf = 1'b0;
    logic [N-1:0] m_pv = '0;
    bit           m_done = 1'b0;

    logic [6:0] obs;
    logic [6:0] exp_v;

    function automatic logic [6:0] model_out(input bit r);
        logic [6:0] o;
        o = '0;
        if (!r) begin
            o[O_RDY]   = !m_pf;
            o[O_VAL]   = m_act;
            o[O_BIT]   = m_act && m_val[m_idx];
            o[O_FIRST] = m_act && (m_idx == 0);
            o[O_LAST]  = m_act && (m_idx == N - 1);
            o[O_BUSY]  = m_act || m_pf;
            o[O_DONE]  = m_done;
        end
        return o;
    endfunction

    function automatic void model_clock(input bit r, input bit lv, input logic [N-1:0] d, input bit st);
        bit accept;
        bit finishing;
        if (r) begin
            m_act = 0; m_val = '0; m_idx = 0; m_pf = 0; m_pv = '0; m_done = 0;
            return;
        end
        accept    = lv && !m_pf;
        finishing = m_act && st && (m_idx == N - 1);
        m_done    = finishing;
        if (m_act && st) begin
            if (finishing) m_act = 0;
            else m_idx = m_idx + 1;
        end
        if (m_pf && !m_act) begin
            m_act = 1; m_val = m_pv; m_idx = 0; m_pf = 0;
        end
        if (accept) begin
            m_pf = 1; m_pv = d;
        end
    endfunction

    // One clock: drive inputs at the falling edge, sample outputs 1 time unit later,
    // and advance the model across the following rising edge.
    task automatic tick(input bit r, input bit lv, input logic [N-1:0] d, input bit st);
        @(negedge clk);
        rst = r; load_valid = lv; load_data = d; step = st;
        #1;
        obs   = {load_ready, sel_valid, sel_bit, first, last, busy, done};
        exp_v = model_out(r);
        model_clock(r, lv, d, st);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1, 1, 8'h5A, 1);
            checks++;
            if (obs !== 7'b0) begin
                errors++; $display("FAIL reset_outputs cyc%0d got %b want %b", i, obs, 7'b0);
            end
        end
        tick(0, 0, '0, 0);
        checks++;
        if (obs !== 7'b1000000) begin
            errors++; $display("FAIL reset_idle got %b want %b", obs, 7'b1000000);
        end
    endtask

    task automatic test_single();
        logic [31:0] got = '0;
        int nb = 0, ndone = 0, nfirst = 0;
        tick(0, 1, 8'hA5, 1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL single_load got %b want %b", obs, exp_v); end
        for (int i = 0; i < 14; i++) begin
            tick(0, 0, '0, 1);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL single cyc%0d got %b want %b", i, obs, exp_v); end
            if (obs[O_VAL]) begin got[nb] = obs[O_BIT]; nb++; end
            if (obs[O_FIRST]) nfirst++;
            if (obs[O_DONE]) ndone++;
        end
        checks++;
        if (nb != 8 || got[7:0] !== 8'hA5) begin
            errors++; $display("FAIL single_bits got %0d bits %h want 8 bits a5", nb, got[7:0]);
        end
        checks++;
        if (ndone != 1 || nfirst != 1) begin
            errors++; $display("FAIL single_pulses got done=%0d first=%0d want 1 1", ndone, nfirst);
        end
        checks++;
        if (obs[O_BUSY] !== 1'b0 || obs[O_VAL] !== 1'b0) begin
            errors++; $display("FAIL single_end got busy=%b valid=%b want 0 0", obs[O_BUSY], obs[O_VAL]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got = '0;
        int nb = 0, ndone = 0, nfirst = 0, fv = -1, lvc = -1;
        bit lv;
        for (int i = 0; i < 24; i++) begin
            lv = (i == 0) || (i == 2);
            tick(0, lv, (i == 0) ? 8'h0F : 8'hF0, 1);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL b2b cyc%0d got %b want %b", i, obs, exp_v); end
            if (obs[O_VAL]) begin
                got[nb] = obs[O_BIT]; nb++;
                if (fv < 0) fv = i;
                lvc = i;
            end
            if (obs[O_FIRST]) nfirst++;
            if (obs[O_DONE]) ndone++;
        end
        checks++;
        if (nb != 16 || got[15:0] !== 16'hF00F || (lvc - fv + 1) != 16) begin
            errors++; $display("FAIL b2b_stream got %0d bits %h span %0d want 16 bits f00f span 16", nb, got[15:0], lvc - fv + 1);
        end
        checks++;
        if (ndone != 2 || nfirst != 2) begin
            errors++; $display("FAIL b2b_pulses got done=%0d first=%0d want 2 2", ndone, nfirst);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got = '0;
        int nb = 0;
        bit c_sent = 0;
        bit lv;
        tick(0, 1, 8'h3C, 0);
        tick(0, 0, '0, 0);
        tick(0, 1, 8'hC3, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, 8'h5A, 0);
            checks++;
            if (obs[O_RDY] !== 1'b0 || obs !== exp_v) begin
                errors++; $display("FAIL bp_full cyc%0d got %b want %b", i, obs, exp_v);
            end
            if (obs[O_VAL]) begin got[nb] = obs[O_BIT]; end
        end
        for (int i = 0; i < 40; i++) begin
            lv = !c_sent;
            tick(0, lv, 8'h5A, 1);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL bp cyc%0d got %b want %b", i, obs, exp_v); end
            if (lv && obs[O_RDY]) c_sent = 1;
            if (obs[O_VAL]) begin
                if (obs[O_FIRST] && nb == 8) begin
                    checks++;
                    if (obs[O_RDY] !== 1'b1) begin
                        errors++; $display("FAIL bp_ready_after_transfer got %b want 1", obs[O_RDY]);
                    end
                end
                got[nb] = obs[O_BIT]; nb++;
            end
        end
        checks++;
        if (nb != 24 || got[23:0] !== 24'h5AC33C) begin
            errors++; $display("FAIL bp_stream got %0d bits %h want 24 bits 5ac33c", nb, got[23:0]);
        end
    endtask

    task automatic test_stall();
        logic [31:0] got = '0;
        int nsteps = 0;
        bit seen_done = 0;
        bit st;
        tick(0, 1, 8'h81, 0);
        for (int i = 1; i < 60 && !seen_done; i++) begin
            st = (i % 3 == 0);
            tick(0, 0, '0, st);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL stall cyc%0d got %b want %b", i, obs, exp_v); end
            if (obs[O_VAL] && st) begin got[nsteps] = obs[O_BIT]; nsteps++; end
            if (obs[O_DONE]) seen_done = 1;
        end
        checks++;
        if (!seen_done || nsteps != 8 || got[7:0] !== 8'h81) begin
            errors++; $display("FAIL stall_steps got done=%0d steps=%0d bits %h want 1 8 81", seen_done, nsteps, got[7:0]);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] got = '0;
        int nb = 0, ndone = 0;
        tick(0, 1, 8'hFF, 1);
        tick(0, 0, '0, 1);
        tick(0, 1, 8'h00, 1);
        tick(0, 0, '0, 1);
        tick(0, 0, '0, 1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL midrst_pre got %b want %b", obs, exp_v); end
        tick(1, 0, '0, 1);
        checks++;
        if (obs !== 7'b0) begin errors++; $display("FAIL midrst_during got %b want %b", obs, 7'b0); end
        tick(0, 0, '0, 0);
        checks++;
        if (obs !== 7'b1000000) begin errors++; $display("FAIL midrst_after got %b want %b", obs, 7'b1000000); end
        tick(0, 1, 8'h01, 1);
        for (int i = 0; i < 14; i++) begin
            tick(0, 0, '0, 1);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL midrst cyc%0d got %b want %b", i, obs, exp_v); end
            if (obs[O_VAL]) begin got[nb] = obs[O_BIT]; nb++; end
            if (obs[O_DONE]) ndone++;
        end
        checks++;
        if (nb != 8 || got[7:0] !== 8'h01 || ndone != 1) begin
            errors++; $display("FAIL midrst_stream got %0d bits %h done=%0d want 8 bits 01 done=1", nb, got[7:0], ndone);
        end
    endtask

    task automatic test_spurious_step();
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, '0, 1);
            checks++;
            if (obs !== 7'b1000000) begin
                errors++; $display("FAIL spurious cyc%0d got %b want %b", i, obs, 7'b1000000);
            end
        end
    endtask

    task automatic test_random();
        bit r, lv, st;
        logic [N-1:0] d;
        int nerr = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            lv = $urandom_range(0, 1) == 1;
            st = $urandom_range(0, 3) != 0;
            d  = N'($urandom);
            tick(r, lv, d, st);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                if (nerr < 10) $display("FAIL random cyc%0d got %b want %b", i, obs, exp_v);
                nerr++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_stall();
        test_mid_reset();
        test_spurious_step();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Drives the select inputs of the Algorithm 3 datapath muxes (mux2to1_1bit chains). It accepts N-bit operands through a valid/ready load port and emits them one bit per step, LSB first, as a mux select stream.
- A ping-pong arrangement (active shifter plus pending buffer) lets the next operand load while the current one streams, so back-to-back multiplications run gap-free.
- Sits between the top-level controller and the Montgomery iteration datapath.

Parameters:
- N, 256, operand width in bits; also the number of select bits emitted per operand (legal N >= 2).
- CNT_W, $clog2(N), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- load_valid  input  1  load_data is valid
- load_ready  output  1  pending buffer can accept an operand
- load_data  input  N  operand to serialise
- step  input  1  datapath consumed the current bit this cycle
- sel_bit  output  1  current select bit (active_sr[0])
- sel_valid  output  1  sel_bit is meaningful
- first  output  1  sel_valid and bit index == 0
- last  output  1  sel_valid and bit index == N-1
- busy  output  1  active shifter or pending buffer occupied
- done  output  1  one-cycle pulse, the cycle after the step that consumed bit N-1

Behaviour:
- Reset (synchronous, active-high, sampled on clk): clears active_valid, pending_full, cnt, active_sr, pend_buf and done. All outputs are 0 while rst is high, including load_ready. Loads presented during reset are dropped.
- load_ready = !pending_full && !rst. It is purely a register-derived value, with no combinational path from step or load_valid.
- A load handshake (load_valid && load_ready) writes load_data to pend_buf and sets pending_full.
- Transfer condition: pending_full && (!active_valid || (step && last)). On transfer:
  - active_sr <= pend_buf, cnt <= 0, active_valid <= 1, pending_full <= 0.
- No load can coincide with a transfer, because load_ready is 0 whenever pending_full is 1.
- Latency: a load accepted at cycle t with the shifter idle gives sel_valid=1 and first=1 at t+2 (t+1 pend_buf written, t+1 transfer, t+2 visible).
- Step when active_valid and cnt < N-1: active_sr shifts right by 1 (zero fill), cnt <= cnt+1.
- Step when last:
  - With pending_full: transfer occurs in the same cycle; the next cycle shows bit0 of the new operand with first=1. done still pulses in that next cycle.
  - Without pending_full: active_valid <= 0 and cnt <= 0, so sel_valid drops the next cycle.
- step while !sel_valid is ignored, with no state change.
- step held low stalls indefinitely: sel_bit, cnt and the flags hold.
- busy = active_valid || pending_full.
- States (implicit, from active_valid/pending_full): IDLE(0,0), RUN(1,0), RUN_PEND(1,1), PEND(0,1). PEND lasts exactly one cycle before the transfer.
- Reset mid-stream discards both operands with no done pulse; the next cycle after rst deasserts is IDLE with load_ready=1.
- cnt never exceeds N-1, with no wrap beyond it.

Decomposition:
- Shared package mont_pkg: N default (OPERAND_W) and CNT_W derivation, shared with the Montgomery core and the mux datapath.
- One sub-module is natural: sel_shift_reg (N-bit load/shift-right register with bit counter and last flag), instantiated once for the active slot. The pending buffer is a plain register in the parent.

Test Plan (N=8):
- Single operand: reset, load 8'hA5, step held high -> sel_bit sequence 1,0,1,0,0,1,0,1; first on bit0, last on bit7; done pulses once 1 cycle after the last step; sel_valid then 0, busy 0.
- Back-to-back: load 8'h0F, then load 8'hF0 while streaming, step always 1 -> 16 contiguous sel_valid cycles with bits 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1; two done pulses; first asserted at bit0 of each operand.
- Backpressure: with active and pending full, load_valid=1 -> load_ready=0 and data not captured; load_ready returns 1 the cycle after the transfer.
- Stall: load 8'h81, step pattern 1,0,0,1,... -> sel_bit and cnt hold during step=0; exactly 8 step-high cycles are needed before done.
- Mid-stream reset: load 8'hFF and 8'h00, pulse rst after 3 steps -> next cycle all outputs 0, no done pulse, load_ready=1 after deassertion; a subsequent load of 8'h01 streams 1 followed by seven 0s.
- Spurious step: step=1 in IDLE with no load -> no sel_valid, no done, busy stays 0.
